// File: rtl/threshold_pair_stage_pkg.sv
// Shared types and constants for the RGB pair threshold stage.
package threshold_pair_stage_pkg;

    localparam int unsigned PIX_W = 8;
    localparam int unsigned SUM_W = 10;
    localparam int unsigned ROW_W = 10;
    localparam int unsigned COL_W = 11;

    localparam logic [PIX_W-1:0] PIX_BLACK = 8'h00;
    localparam logic [PIX_W-1:0] PIX_WHITE = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Stage-1 payload: luminance sums plus frame position of the pair.
    typedef struct packed {
        logic [SUM_W-1:0] sum_even;
        logic [SUM_W-1:0] sum_odd;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        logic             last;
    } stage1_t;

    // Compare against 3*threshold instead of dividing the sum by 3.
    function automatic logic [SUM_W-1:0] sum_limit(input int unsigned thr);
        return SUM_W'(3 * thr);
    endfunction

endpackage

// File: rtl/threshold_pair_stage_pixel_threshold.sv
// One pixel: RGB sum for stage 1, threshold compare of the registered sum for stage 2.
module pixel_threshold
    import threshold_pair_stage_pkg::*;
#(
    parameter int unsigned THRESHOLD = 90,
    parameter bit          INVERT    = 1'b0
) (
    input  logic [PIX_W-1:0] i_red,
    input  logic [PIX_W-1:0] i_green,
    input  logic [PIX_W-1:0] i_blue,
    input  logic [SUM_W-1:0] i_sum,
    output logic [SUM_W-1:0] o_sum_c,
    output logic [PIX_W-1:0] o_pix_c
);

    localparam logic [SUM_W-1:0] LIMIT = sum_limit(THRESHOLD);

    logic w_above;

    assign o_sum_c = SUM_W'(i_red) + SUM_W'(i_green) + SUM_W'(i_blue);
    assign w_above = (i_sum > LIMIT);
    assign o_pix_c = (w_above ^ INVERT) ? PIX_WHITE : PIX_BLACK;

endmodule

// File: rtl/threshold_pair_stage.sv
// Binarises even/odd RGB pixel pairs and tracks frame position, done and error status.
module threshold_pair_stage
    import threshold_pair_stage_pkg::*;
#(
    parameter int unsigned IMAGE_WIDTH  = 768,
    parameter int unsigned IMAGE_HEIGHT = 512,
    parameter int unsigned THRESHOLD    = 90,
    parameter bit          INVERT       = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vertical_Pulse,
    input  logic             horizontal_Pulse,
    input  logic [PIX_W-1:0] data_Red_Even,
    input  logic [PIX_W-1:0] data_Green_Even,
    input  logic [PIX_W-1:0] data_Blue_Even,
    input  logic [PIX_W-1:0] data_Red_Odd,
    input  logic [PIX_W-1:0] data_Green_Odd,
    input  logic [PIX_W-1:0] data_Blue_Odd,
    output logic [PIX_W-1:0] thr_Even,
    output logic [PIX_W-1:0] thr_Odd,
    output logic             out_Valid,
    output logic [ROW_W-1:0] out_Row,
    output logic [COL_W-1:0] out_Column,
    output logic             frame_Done,
    output logic             frame_Error
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 2);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);

    state_t           r_state;
    logic             r_vs_prev;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    stage1_t          r_s1;
    logic             r_s1_valid;

    logic             w_vs_rise;
    logic             w_open;
    logic             w_accept;
    logic [ROW_W-1:0] w_row;
    logic [COL_W-1:0] w_col;
    logic             w_col_wrap;
    logic             w_last;
    logic             w_overflow;
    logic             w_short;
    logic [SUM_W-1:0] w_sum_even;
    logic [SUM_W-1:0] w_sum_odd;
    logic [PIX_W-1:0] w_pix_even;
    logic [PIX_W-1:0] w_pix_odd;

    // A vsync rise restarts the frame, so a pair arriving with it lands at row 0, col 0.
    assign w_vs_rise  = vertical_Pulse & ~r_vs_prev;
    assign w_open     = (r_state == ST_ARMED) || (r_state == ST_ACTIVE);
    assign w_accept   = horizontal_Pulse & (w_vs_rise | w_open);
    assign w_row      = w_vs_rise ? '0 : r_row;
    assign w_col      = w_vs_rise ? '0 : r_col;
    assign w_col_wrap = (w_col == COL_LAST);
    assign w_last     = w_accept & w_col_wrap & (w_row == ROW_LAST);
    assign w_overflow = horizontal_Pulse & ~w_vs_rise & (r_state == ST_DONE);
    assign w_short    = w_vs_rise & (r_state == ST_ACTIVE);

    pixel_threshold #(.THRESHOLD(THRESHOLD), .INVERT(INVERT)) u_px_even (
        .i_red   (data_Red_Even),
        .i_green (data_Green_Even),
        .i_blue  (data_Blue_Even),
        .i_sum   (r_s1.sum_even),
        .o_sum_c (w_sum_even),
        .o_pix_c (w_pix_even)
    );

    pixel_threshold #(.THRESHOLD(THRESHOLD), .INVERT(INVERT)) u_px_odd (
        .i_red   (data_Red_Odd),
        .i_green (data_Green_Odd),
        .i_blue  (data_Blue_Odd),
        .i_sum   (r_s1.sum_odd),
        .o_sum_c (w_sum_odd),
        .o_pix_c (w_pix_odd)
    );

    // Frame FSM, position counters and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_vs_prev   <= 1'b0;
            r_row       <= '0;
            r_col       <= '0;
            frame_Error <= 1'b0;
        end else begin
            r_vs_prev <= vertical_Pulse;

            if (w_accept) begin
                r_state <= w_last ? ST_DONE : ST_ACTIVE;
            end else if (w_vs_rise) begin
                r_state <= ST_ARMED;
            end

            if (w_accept) begin
                if (w_col_wrap) begin
                    r_col <= '0;
                    r_row <= w_last ? '0 : w_row + ROW_W'(1);
                end else begin
                    r_col <= w_col + COL_W'(2);
                    r_row <= w_row;
                end
            end else if (w_vs_rise) begin
                r_row <= '0;
                r_col <= '0;
            end

            if (w_vs_rise) begin
                frame_Error <= w_short;
            end else if (w_overflow) begin
                frame_Error <= 1'b1;
            end
        end
    end

    // Two-stage pixel pipeline: sums and position, then compare results.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
            out_Valid  <= 1'b0;
            frame_Done <= 1'b0;
            thr_Even   <= '0;
            thr_Odd    <= '0;
            out_Row    <= '0;
            out_Column <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1.sum_even <= w_sum_even;
                r_s1.sum_odd  <= w_sum_odd;
                r_s1.row      <= w_row;
                r_s1.col      <= w_col;
                r_s1.last     <= w_last;
            end

            out_Valid  <= r_s1_valid;
            frame_Done <= r_s1_valid & r_s1.last;
            if (r_s1_valid) begin
                thr_Even   <= w_pix_even;
                thr_Odd    <= w_pix_odd;
                out_Row    <= r_s1.row;
                out_Column <= r_s1.col;
            end
        end
    end

endmodule

// File: tb/tb_threshold_pair_stage.sv
// Bench for threshold_pair_stage on a reduced 8x4 frame, normal and inverted polarity.
module tb_threshold_pair_stage;

    localparam int W     = 8;
    localparam int H     = 4;
    localparam int THR   = 90;
    localparam int PAIRS = W * H / 2;

    logic       clk;
    logic       rst;
    logic       vs;
    logic       hs;
    logic [7:0] re, ge, be, ro, go, bo;

    logic [7:0]  d_te, d_to, i_te, i_to;
    logic        d_valid, d_done, d_err, i_valid, i_done, i_err;
    logic [9:0]  d_row, i_row;
    logic [10:0] d_col, i_col;

    threshold_pair_stage #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .THRESHOLD(THR), .INVERT(1'b0)) u_dut (
        .clk(clk), .reset(rst), .vertical_Pulse(vs), .horizontal_Pulse(hs),
        .data_Red_Even(re), .data_Green_Even(ge), .data_Blue_Even(be),
        .data_Red_Odd(ro), .data_Green_Odd(go), .data_Blue_Odd(bo),
        .thr_Even(d_te), .thr_Odd(d_to), .out_Valid(d_valid), .out_Row(d_row),
        .out_Column(d_col), .frame_Done(d_done), .frame_Error(d_err)
    );

    threshold_pair_stage #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .THRESHOLD(THR), .INVERT(1'b1)) u_inv (
        .clk(clk), .reset(rst), .vertical_Pulse(vs), .horizontal_Pulse(hs),
        .data_Red_Even(re), .data_Green_Even(ge), .data_Blue_Even(be),
        .data_Red_Odd(ro), .data_Green_Odd(go), .data_Blue_Odd(bo),
        .thr_Even(i_te), .thr_Odd(i_to), .out_Valid(i_valid), .out_Row(i_row),
        .out_Column(i_col), .frame_Done(i_done), .frame_Error(i_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, want, $time);
        end
    endtask

    // Expected binary pixel from the mean-luminance rule.
    function automatic logic [7:0] bw(input logic [7:0] r, input logic [7:0] g,
                                      input logic [7:0] b, input bit inv);
        int  s;
        bit  white;
        s     = int'(r) + int'(g) + int'(b);
        white = (s > 3 * THR);
        return (white ^ inv) ? 8'hFF : 8'h00;
    endfunction

    typedef struct {
        bit         v;
        int         row;
        int         col;
        bit         last;
        logic [7:0] te, to, tei, toi;
    } exp_t;

    // Frame model: mode 0 = no frame, 1 = frame open, 2 = frame complete.
    int   m_mode, m_cnt, m_row, m_col;
    bit   m_err, m_vsp, rise;
    exp_t e1, e2;

    logic [36:0] rec[$];
    int          n_done;
    int          done_row, done_col;

    always begin
        @(posedge clk);
        if (rst) begin
            m_mode = 0; m_cnt = 0; m_err = 0; m_vsp = 0;
            e1.v = 0; e2.v = 0; m_row = 0; m_col = 0;
        end else begin
            rise  = vs && !m_vsp;
            m_vsp = vs;
            if (rise) begin
                m_err  = (m_mode == 1) && (m_cnt > 0);
                m_mode = 1;
                m_cnt  = 0;
            end else if (hs && m_mode == 2) begin
                m_err = 1;
            end
            e2   = e1;
            e1.v = 0;
            if (hs && m_mode == 1) begin
                e1.v    = 1;
                e1.row  = m_cnt / (W / 2);
                e1.col  = 2 * (m_cnt % (W / 2));
                e1.last = (m_cnt == PAIRS - 1);
                e1.te   = bw(re, ge, be, 1'b0);
                e1.to   = bw(ro, go, bo, 1'b0);
                e1.tei  = bw(re, ge, be, 1'b1);
                e1.toi  = bw(ro, go, bo, 1'b1);
                m_cnt++;
                if (e1.last) m_mode = 2;
            end
            if (e2.v) begin
                m_row = e2.row;
                m_col = e2.col;
            end
        end
        #1;
        chk("valid", 64'(d_valid), 64'(e2.v));
        chk("done", 64'(d_done), 64'(e2.v && e2.last));
        chk("error", 64'(d_err), 64'(m_err));
        chk("row", 64'(d_row), 64'(m_row));
        chk("col", 64'(d_col), 64'(m_col));
        chk("inv_valid", 64'(i_valid), 64'(e2.v));
        chk("inv_done", 64'(i_done), 64'(e2.v && e2.last));
        chk("inv_error", 64'(i_err), 64'(m_err));
        chk("inv_row", 64'(i_row), 64'(m_row));
        chk("inv_col", 64'(i_col), 64'(m_col));
        if (e2.v) begin
            chk("thr_even", 64'(d_te), 64'(e2.te));
            chk("thr_odd", 64'(d_to), 64'(e2.to));
            chk("inv_thr_even", 64'(i_te), 64'(e2.tei));
            chk("inv_thr_odd", 64'(i_to), 64'(e2.toi));
        end
        if (d_valid) rec.push_back({d_te, d_to, d_row, d_col});
        if (d_done) begin
            n_done++;
            done_row = int'(d_row);
            done_col = int'(d_col);
        end
    end

    function automatic logic [7:0] pv(input int idx, input int k);
        if (idx == 3) return (k < 3) ? 8'd90 : 8'd91;
        return 8'((idx * 47 + k * 71 + 13) % 256);
    endfunction

    task automatic send_rgb(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                            input logic [7:0] d, input logic [7:0] e, input logic [7:0] f);
        hs = 1'b1;
        re = a; ge = b; be = c; ro = d; go = e; bo = f;
        @(negedge clk);
        hs = 1'b0;
    endtask

    task automatic send(input int idx);
        send_rgb(pv(idx, 0), pv(idx, 1), pv(idx, 2), pv(idx, 3), pv(idx, 4), pv(idx, 5));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic vsync_pulse();
        vs = 1'b1;
        @(negedge clk);
        vs = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; hs = 1'b0; vs = 1'b0;
        idle(2);
        rst = 1'b0;
        rec.delete();
        n_done = 0;
    endtask

    logic [36:0] golden[$];
    logic [36:0] entry;

    initial begin
        rst = 1'b1; vs = 1'b0; hs = 1'b0;
        re = '0; ge = '0; be = '0; ro = '0; go = '0; bo = '0;
        n_done = 0; done_row = -1; done_col = -1;
        idle(3);
        chk("reset_valid", 64'(d_valid), 64'd0);
        chk("reset_error", 64'(d_err), 64'd0);
        chk("reset_thr_even", 64'(d_te), 64'd0);
        chk("reset_row_col", 64'({d_row, d_col}), 64'd0);
        rst = 1'b0;

        // First pair just above / exactly at threshold.
        vsync_pulse();
        send_rgb(8'd91, 8'd91, 8'd91, 8'd90, 8'd90, 8'd90);
        idle(1);
        chk("first_valid", 64'(d_valid), 64'd1);
        chk("first_thr_even", 64'(d_te), 64'hFF);
        chk("first_thr_odd", 64'(d_to), 64'h00);
        chk("first_row_col", 64'({d_row, d_col}), 64'd0);

        // Full frame, continuous hsync.
        do_reset();
        vsync_pulse();
        for (int i = 0; i < PAIRS; i++) send(i);
        idle(4);
        chk("full_count", 64'(rec.size()), 64'd16);
        chk("full_done_count", 64'(n_done), 64'd1);
        chk("full_done_row", 64'(done_row), 64'd3);
        chk("full_done_col", 64'(done_col), 64'd6);
        chk("full_error", 64'(d_err), 64'd0);
        golden = rec;

        // Same frame with hsync gaps.
        do_reset();
        vsync_pulse();
        for (int i = 0; i < PAIRS; i++) begin
            if (i % 3 != 0) idle(1 + (i % 3));
            send(i);
        end
        idle(4);
        chk("gap_count", 64'(rec.size()), 64'd16);
        for (int i = 0; i < rec.size() && i < golden.size(); i++)
            chk("gap_seq", 64'(rec[i]), 64'(golden[i]));
        chk("gap_done_count", 64'(n_done), 64'd1);

        // Extra pair after the frame completed.
        send(7);
        idle(3);
        chk("overflow_no_output", 64'(rec.size()), 64'd16);
        chk("overflow_error", 64'(d_err), 64'd1);

        // vsync and hsync together after a done frame: new frame, error cleared.
        vs = 1'b1;
        send(5);
        vs = 1'b0;
        idle(1);
        chk("vs_hs_valid", 64'(d_valid), 64'd1);
        chk("vs_hs_row_col", 64'({d_row, d_col}), 64'd0);
        chk("vs_hs_error", 64'(d_err), 64'd0);

        // Short frame: vsync after five pairs.
        do_reset();
        vsync_pulse();
        for (int i = 0; i < 5; i++) send(i);
        vsync_pulse();
        idle(1);
        chk("short_error", 64'(d_err), 64'd1);
        rec.delete();
        for (int i = 0; i < PAIRS; i++) send(i);
        idle(4);
        chk("short_restart_count", 64'(rec.size()), 64'd16);
        entry = (rec.size() > 0) ? rec[0] : '1;
        chk("short_restart_pos", 64'(entry[20:0]), 64'd0);
        chk("short_error_sticky", 64'(d_err), 64'd1);
        vsync_pulse();
        idle(1);
        chk("short_error_cleared", 64'(d_err), 64'd0);

        // White pixel in both polarities, then reset mid-frame.
        do_reset();
        vsync_pulse();
        send_rgb(8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255);
        idle(1);
        chk("white_thr", 64'(d_te), 64'hFF);
        chk("white_inv_even", 64'(i_te), 64'h00);
        chk("white_inv_odd", 64'(i_to), 64'h00);
        send(1);
        send(2);
        rst = 1'b1;
        send(3);
        chk("midreset_valid", 64'(d_valid), 64'd0);
        chk("midreset_done", 64'(d_done), 64'd0);
        idle(2);
        chk("midreset_valid_later", 64'(d_valid), 64'd0);
        chk("midreset_no_done", 64'(n_done), 64'd0);
        rst = 1'b0;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
